// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer for the five-stage MIPS core: run/step/pause control, load-use stalls,
// taken-branch flushes and a drain-to-halt sequence when a HALT instruction reaches ID.
module pipeline_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_SZ       = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_step,
  input  logic              i_halt_req,
  input  logic              i_id_instr_halt,
  input  logic              i_branch_taken,
  input  logic              i_id_ex_mem_read,
  input  logic [4:0]        i_id_ex_rt,
  input  logic [4:0]        i_if_id_rs,
  input  logic [4:0]        i_if_id_rt,
  output logic              o_pc_en,
  output logic              o_if_id_en,
  output logic              o_if_id_flush,
  output logic              o_id_ex_en,
  output logic              o_id_ex_flush,
  output logic              o_ex_mem_en,
  output logic              o_mem_wb_en,
  output logic [2:0]        o_state,
  output logic              o_halted,
  output logic [CNT_SZ-1:0] o_cycle_cnt
);

  localparam int unsigned DrainW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [DrainW-1:0] DrainInit = DrainW'(DRAIN_CYCLES);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRun    = 3'd1,
    StStep   = 3'd2,
    StDrain  = 3'd3,
    StHalted = 3'd4
  } state_e;

  state_e              state_q;
  logic [DrainW-1:0]   drain_cnt_q;
  logic [CNT_SZ-1:0]   cycle_cnt_q;

  logic load_use;
  logic active;
  logic halt_dec;
  logic cnt_inc;

  assign load_use = i_id_ex_mem_read && (i_id_ex_rt != 5'd0) &&
                    ((i_id_ex_rt == i_if_id_rs) || (i_id_ex_rt == i_if_id_rt));
  assign active   = (state_q == StRun) || (state_q == StStep);
  // A HALT stuck behind a load-use stall is not decoded until the stall clears.
  assign halt_dec = active && i_id_instr_halt && !load_use;
  assign cnt_inc  = active || (state_q == StDrain);

  always_comb begin
    o_pc_en       = 1'b0;
    o_if_id_en    = 1'b0;
    o_if_id_flush = 1'b0;
    o_id_ex_en    = 1'b0;
    o_id_ex_flush = 1'b0;
    o_ex_mem_en   = 1'b0;
    o_mem_wb_en   = 1'b0;
    if (!i_reset) begin
      if ((state_q == StDrain) || halt_dec || (active && load_use)) begin
        // Front end frozen, bubble into ID/EX, back end keeps retiring.
        o_id_ex_en    = 1'b1;
        o_id_ex_flush = 1'b1;
        o_ex_mem_en   = 1'b1;
        o_mem_wb_en   = 1'b1;
      end else if (active) begin
        o_pc_en       = 1'b1;
        o_if_id_en    = 1'b1;
        o_if_id_flush = i_branch_taken;
        o_id_ex_en    = 1'b1;
        o_ex_mem_en   = 1'b1;
        o_mem_wb_en   = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= StIdle;
      drain_cnt_q <= '0;
      cycle_cnt_q <= '0;
    end else begin
      if (cnt_inc && (cycle_cnt_q != '1)) begin
        cycle_cnt_q <= cycle_cnt_q + CNT_SZ'(1);
      end
      case (state_q)
        StIdle: begin
          if (i_start) begin
            state_q <= StRun;
          end else if (i_step) begin
            state_q <= StStep;
          end
        end
        StRun: begin
          if (halt_dec) begin
            state_q     <= StDrain;
            drain_cnt_q <= DrainInit;
          end else if (i_halt_req) begin
            state_q <= StIdle;
          end
        end
        StStep: begin
          if (halt_dec) begin
            state_q     <= StDrain;
            drain_cnt_q <= DrainInit;
          end else begin
            state_q <= StIdle;
          end
        end
        StDrain: begin
          drain_cnt_q <= drain_cnt_q - DrainW'(1);
          if (drain_cnt_q == DrainW'(1)) begin
            state_q <= StHalted;
          end
        end
        StHalted: begin
          state_q <= StHalted;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign o_state     = i_reset ? 3'd0 : state_q;
  assign o_halted    = !i_reset && (state_q == StHalted);
  assign o_cycle_cnt = i_reset ? '0 : cycle_cnt_q;

endmodule
